// File: rtl/game_object_renderer.sv
`default_nettype none
// ============================================================================
// Module      : game_object_renderer
// Description : VGA timing plus RGB444 rendering of a Pong ball and two
//               paddles from frame-shadowed object registers.
// Revision    : 1.0 - initial release
// ============================================================================
module game_object_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_W  = 8,
    parameter int PADDLE_H  = 64,
    parameter int LPADDLE_X = 16,
    parameter int RPADDLE_X = 616
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        pix_ce,
    input  logic [31:0] obj_reg0,
    input  logic [31:0] obj_reg1,
    input  logic [31:0] obj_reg2,
    input  logic [31:0] obj_reg3,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int         c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] c_BALL    = 11'(BALL_SIZE);
    localparam logic [10:0] c_PAD_W   = 11'(PADDLE_W);
    localparam logic [10:0] c_PAD_H   = 11'(PADDLE_H);
    localparam logic [10:0] c_LPAD_X  = 11'(LPADDLE_X);
    localparam logic [10:0] c_RPAD_X  = 11'(RPADDLE_X);

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0]  ball_x_q, ball_y_q, lpad_y_q, rpad_y_q;
    logic        en_q;
    logic [11:0] bg_q, fg_q;
    logic        frame_start_q;
    logic        act1_q, hs1_q, vs1_q, ball_hit_q, lpad_hit_q, rpad_hit_q;
    logic        de_q, hsync_q, vsync_q;
    logic [11:0] rgb_q;

    logic        load;
    logic        active, hs_level, vs_level;
    logic        ball_hit, lpad_hit, rpad_hit;
    logic [10:0] h_ext, v_ext, bx_ext, by_ext, ly_ext, ry_ext;
    logic        unused_bits;

    assign unused_bits = ^{obj_reg0[31:26], obj_reg0[15:10], obj_reg1[31:10],
                           obj_reg2[31:10], obj_reg3[30:24]};

    assign load = pix_ce && (h_cnt_q == c_H_LAST) && (v_cnt_q == c_V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == c_H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Hit tests widened to 11 bits so a position near 1023 cannot wrap its far edge.
    assign h_ext  = {1'b0, h_cnt_q};
    assign v_ext  = {1'b0, v_cnt_q};
    assign bx_ext = {1'b0, ball_x_q};
    assign by_ext = {1'b0, ball_y_q};
    assign ly_ext = {1'b0, lpad_y_q};
    assign ry_ext = {1'b0, rpad_y_q};

    assign ball_hit = (h_ext >= bx_ext) && (h_ext < bx_ext + c_BALL) &&
                      (v_ext >= by_ext) && (v_ext < by_ext + c_BALL);
    assign lpad_hit = (h_ext >= c_LPAD_X) && (h_ext < c_LPAD_X + c_PAD_W) &&
                      (v_ext >= ly_ext) && (v_ext < ly_ext + c_PAD_H);
    assign rpad_hit = (h_ext >= c_RPAD_X) && (h_ext < c_RPAD_X + c_PAD_W) &&
                      (v_ext >= ry_ext) && (v_ext < ry_ext + c_PAD_H);

    assign active   = (h_cnt_q < c_H_ACT) && (v_cnt_q < c_V_ACT);
    assign hs_level = !((h_cnt_q >= c_HS_START) && (h_cnt_q < c_HS_END));
    assign vs_level = !((v_cnt_q >= c_VS_START) && (v_cnt_q < c_VS_END));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            ball_x_q      <= '0;
            ball_y_q      <= '0;
            lpad_y_q      <= '0;
            rpad_y_q      <= '0;
            en_q          <= 1'b0;
            bg_q          <= '0;
            fg_q          <= '0;
            frame_start_q <= 1'b0;
            act1_q        <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            ball_hit_q    <= 1'b0;
            lpad_hit_q    <= 1'b0;
            rpad_hit_q    <= 1'b0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= '0;
        end else begin
            frame_start_q <= load;
            if (load) begin
                ball_x_q <= obj_reg0[9:0];
                ball_y_q <= obj_reg0[25:16];
                lpad_y_q <= obj_reg1[9:0];
                rpad_y_q <= obj_reg2[9:0];
                en_q     <= obj_reg3[31];
                bg_q     <= obj_reg3[23:12];
                fg_q     <= obj_reg3[11:0];
            end
            if (pix_ce) begin
                h_cnt_q    <= h_cnt_d;
                v_cnt_q    <= v_cnt_d;
                act1_q     <= active;
                hs1_q      <= hs_level;
                vs1_q      <= vs_level;
                ball_hit_q <= ball_hit;
                lpad_hit_q <= lpad_hit;
                rpad_hit_q <= rpad_hit;
                de_q       <= act1_q;
                hsync_q    <= hs1_q;
                vsync_q    <= vs1_q;
                if (!act1_q)
                    rgb_q <= '0;
                else if (en_q && (ball_hit_q || lpad_hit_q || rpad_hit_q))
                    rgb_q <= fg_q;
                else
                    rgb_q <= bg_q;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_game_object_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_object_renderer
// Description : Scoreboard bench for game_object_renderer on a reduced raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_object_renderer;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int BS = 8, PW = 8, PH = 16, LX = 4, RX = 56;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        pix_ce = 1'b0;
    logic [31:0] obj_reg0 = '0, obj_reg1 = '0, obj_reg2 = '0, obj_reg3 = '0;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] rgb;

    game_object_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH),
        .LPADDLE_X(LX), .RPADDLE_X(RX)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .pix_ce(pix_ce),
        .obj_reg0(obj_reg0), .obj_reg1(obj_reg1), .obj_reg2(obj_reg2), .obj_reg3(obj_reg3),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic hs; logic vs; logic de; logic [11:0] rgb; int frame; int h; int v; } exp_t;
    typedef struct { int frame; int h; int v; logic [11:0] rgb; } probe_t;
    typedef struct { logic [31:0] r0; logic [31:0] r1; logic [31:0] r2; logic [31:0] r3;
                     int h; int v; logic [11:0] rgb; } vec_t;

    exp_t        sb_q[$];
    probe_t      probes[$];
    exp_t        last_exp;
    int          mh = 0, mv = 0, mframe = 0, fs_count = 0;
    logic [31:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    int          n_checks = 0, n_fail = 0;
    logic        ce_mode = 1'b0;
    logic [1:0]  ce_div = '0;

    function automatic exp_t reset_entry();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.rgb = '0;
        e.frame = -1; e.h = -1; e.v = -1;
        return e;
    endfunction

    // Reference pixel model, driven only by the bench's own shadow copies.
    function automatic exp_t model(int h, int v);
        exp_t e;
        int bx, by, ly, ry;
        logic hit;
        bx = int'(s0[9:0]); by = int'(s0[25:16]);
        ly = int'(s1[9:0]); ry = int'(s2[9:0]);
        hit = (h >= bx && h < bx + BS && v >= by && v < by + BS) ||
              (h >= LX && h < LX + PW && v >= ly && v < ly + PH) ||
              (h >= RX && h < RX + PW && v >= ry && v < ry + PH);
        e.de  = (h < HA) && (v < VA);
        e.hs  = !(h >= HA + HF && h < HA + HF + HS);
        e.vs  = !(v >= VA + VF && v < VA + VF + VS);
        e.rgb = !e.de ? 12'h000 : (!s3[31] ? s3[23:12] : (hit ? s3[11:0] : s3[23:12]));
        e.frame = mframe; e.h = h; e.v = v;
        return e;
    endfunction

    function automatic logic [31:0] mk_ball(int x, int y);
        return {6'd0, 10'(y), 6'd0, 10'(x)};
    endfunction

    function automatic logic [31:0] mk_col(logic en, logic [11:0] bg, logic [11:0] fg);
        return {en, 7'd0, bg, fg};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge ACLK) begin
        ce_div = ce_div + 2'd1;
        pix_ce = ce_mode ? (ce_div == 2'd0) : 1'b1;
    end

    // Scoreboard: expectation pushed at each pixel enable, popped from the DUT output one enable later.
    always begin
        exp_t e;
        logic was_ce, exp_fs;
        @(posedge ACLK);
        if (!ARESETN) begin
            mh = 0; mv = 0; mframe++;
            s0 = '0; s1 = '0; s2 = '0; s3 = '0;
            sb_q.delete();
            sb_q.push_back(reset_entry());
            last_exp = reset_entry();
        end else begin
            was_ce = pix_ce;
            exp_fs = 1'b0;
            if (pix_ce) begin
                sb_q.push_back(model(mh, mv));
                if (mh == HT - 1 && mv == VT - 1) begin
                    s0 = obj_reg0; s1 = obj_reg1; s2 = obj_reg2; s3 = obj_reg3;
                    mframe++; exp_fs = 1'b1; mh = 0; mv = 0;
                end else if (mh == HT - 1) begin
                    mh = 0; mv++;
                end else begin
                    mh++;
                end
            end
            #1;
            check("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
            if (exp_fs) fs_count++;
            if (was_ce) begin
                e = sb_q.pop_front();
                n_checks++;
                if ({hsync, vsync, de, rgb} !== {e.hs, e.vs, e.de, e.rgb}) begin
                    n_fail++;
                    $display("FAIL pixel f%0d (%0d,%0d): got hs=%b vs=%b de=%b rgb=%h, expected hs=%b vs=%b de=%b rgb=%h",
                             e.frame, e.h, e.v, hsync, vsync, de, rgb, e.hs, e.vs, e.de, e.rgb);
                end
                for (int i = probes.size() - 1; i >= 0; i--) begin
                    if (probes[i].frame == e.frame && probes[i].h == e.h && probes[i].v == e.v) begin
                        check($sformatf("probe f%0d (%0d,%0d) rgb", e.frame, e.h, e.v),
                              {20'd0, rgb}, {20'd0, probes[i].rgb});
                        probes.delete(i);
                    end
                end
                last_exp = e;
            end else begin
                check("hold between enables", {17'd0, hsync, vsync, de, rgb},
                      {17'd0, last_exp.hs, last_exp.vs, last_exp.de, last_exp.rgb});
            end
        end
    end

    task automatic wait_fs(input int limit);
        int start;
        start = fs_count;
        for (int i = 0; i < limit; i++) begin
            @(negedge ACLK);
            if (fs_count != start) break;
        end
        n_checks++;
        if (fs_count == start) begin
            n_fail++;
            $display("FAIL wait_frame_start: no pulse within %0d cycles", limit);
        end
    endtask

    task automatic wait_pos(input int v, input int h, input int limit);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge ACLK);
            if (mv == v && mh >= h) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_pos (%0d,%0d): not reached within %0d cycles", h, v, limit);
        end
    endtask

    task automatic add_probe(input int f, input int h, input int v, input logic [11:0] c);
        probe_t p;
        p.frame = f; p.h = h; p.v = v; p.rgb = c;
        probes.push_back(p);
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] ball_a, col_a, col_off, col_mid;
        ball_a  = mk_ball(20, 10);
        col_a   = mk_col(1'b1, 12'h000, 12'hFFF);
        col_off = mk_col(1'b0, 12'h00F, 12'hFFF);
        col_mid = mk_col(1'b1, 12'h0A5, 12'hFFF);
        // Ball alone: edges are inclusive low, exclusive high.
        vecs[0]  = '{ball_a, 32'd200, 32'd200, col_a, 20, 10, 12'hFFF};
        vecs[1]  = '{ball_a, 32'd200, 32'd200, col_a, 27, 17, 12'hFFF};
        vecs[2]  = '{ball_a, 32'd200, 32'd200, col_a, 28, 17, 12'h000};
        vecs[3]  = '{ball_a, 32'd200, 32'd200, col_a, 20, 18, 12'h000};
        vecs[4]  = '{ball_a, 32'd200, 32'd200, col_a, 19, 10, 12'h000};
        // Paddles: left at top, right clipped by the bottom of the active area.
        vecs[5]  = '{mk_ball(200, 200), 32'd0, 32'd40, col_a, 4, 0, 12'hFFF};
        vecs[6]  = '{mk_ball(200, 200), 32'd0, 32'd40, col_a, 11, 15, 12'hFFF};
        vecs[7]  = '{mk_ball(200, 200), 32'd0, 32'd40, col_a, 11, 16, 12'h000};
        vecs[8]  = '{mk_ball(200, 200), 32'd0, 32'd40, col_a, 12, 0, 12'h000};
        vecs[9]  = '{mk_ball(200, 200), 32'd0, 32'd40, col_a, 56, 47, 12'hFFF};
        vecs[10] = '{mk_ball(200, 200), 32'd0, 32'd40, col_a, 63, 40, 12'hFFF};
        vecs[11] = '{mk_ball(200, 200), 32'd0, 32'd40, col_a, 56, 39, 12'h000};
        // Objects disabled: background everywhere active, zero in blanking.
        vecs[12] = '{ball_a, 32'd0, 32'd40, col_off, 20, 10, 12'h00F};
        vecs[13] = '{ball_a, 32'd0, 32'd40, col_off, 70, 10, 12'h000};

        repeat (4) @(negedge ACLK);
        check("reset hsync", {31'd0, hsync}, 32'd1);
        check("reset vsync", {31'd0, vsync}, 32'd1);
        check("reset de", {31'd0, de}, 32'd0);
        check("reset rgb", {20'd0, rgb}, 32'd0);
        check("reset frame_start", {31'd0, frame_start}, 32'd0);
        ARESETN = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (i == 0 || vecs[i].r0 != vecs[i-1].r0 || vecs[i].r1 != vecs[i-1].r1 ||
                vecs[i].r2 != vecs[i-1].r2 || vecs[i].r3 != vecs[i-1].r3) begin
                obj_reg0 = vecs[i].r0; obj_reg1 = vecs[i].r1;
                obj_reg2 = vecs[i].r2; obj_reg3 = vecs[i].r3;
                wait_fs(2 * HT * VT);
            end
            add_probe(mframe, vecs[i].h, vecs[i].v, vecs[i].rgb);
        end

        // Mid-frame register change must not tear the frame in progress.
        obj_reg0 = ball_a; obj_reg1 = 32'd200; obj_reg2 = 32'd200; obj_reg3 = col_mid;
        wait_fs(2 * HT * VT);
        add_probe(mframe, 20, 10, 12'hFFF);
        add_probe(mframe, 40, 30, 12'h0A5);
        wait_pos(24, 0, 2 * HT * VT);
        obj_reg0 = mk_ball(40, 30);
        add_probe(mframe + 1, 40, 30, 12'hFFF);
        add_probe(mframe + 1, 20, 10, 12'h0A5);
        wait_fs(2 * HT * VT);
        wait_pos(40, 0, 2 * HT * VT);

        // Quarter-rate pixel enable, then an asynchronous reset inside the active area.
        ce_mode = 1'b1;
        wait_pos(42, 30, 8 * HT * VT);
        check("pre-reset de", {31'd0, de}, 32'd1);
        ARESETN = 1'b0;
        #1;
        check("async reset hsync", {31'd0, hsync}, 32'd1);
        check("async reset vsync", {31'd0, vsync}, 32'd1);
        check("async reset de", {31'd0, de}, 32'd0);
        check("async reset rgb", {20'd0, rgb}, 32'd0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        add_probe(mframe, 20, 10, 12'h000);
        add_probe(mframe, 0, 0, 12'h000);
        wait_pos(12, 0, 8 * HT * VT);

        foreach (probes[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL probe f%0d (%0d,%0d): pixel never produced", probes[i].frame, probes[i].h, probes[i].v);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
